// File: rtl/dco_freq_cal.sv
// dco_freq_cal: calibration controller for a one-hot coded DCO.
// Steps the code index linearly, counting DCO rising edges over a fixed
// window of clk cycles after each code change, until the count falls within
// target_cnt +/- tol, the code range runs out, or the search direction reverses.
module dco_freq_cal #(
    parameter int CODE_W     = 10,
    parameter int CNT_W      = 8,
    parameter int WIN_CYC    = 64,
    parameter int SETTLE_CYC = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [CNT_W-1:0]  target_cnt,
    input  logic [CNT_W-1:0]  tol,
    input  logic              dco_sync,
    output logic [CODE_W-1:0] lambda,
    output logic              e,
    output logic              busy,
    output logic              done,
    output logic              locked,
    output logic              sat,
    output logic [CNT_W-1:0]  meas_cnt
);

    localparam int IDX_W   = (CODE_W > 1) ? $clog2(CODE_W) : 1;
    localparam int TMR_MAX = (WIN_CYC > SETTLE_CYC) ? WIN_CYC : SETTLE_CYC;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SETTLE = 3'd1;
    localparam logic [2:0] S_MEAS   = 3'd2;
    localparam logic [2:0] S_CMP    = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    localparam logic [IDX_W-1:0]  IDX_LAST    = IDX_W'(CODE_W - 1);
    localparam logic [TMR_W-1:0]  SETTLE_LAST = TMR_W'(SETTLE_CYC - 1);
    localparam logic [TMR_W-1:0]  WIN_LAST    = TMR_W'(WIN_CYC - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX     = {CNT_W{1'b1}};
    localparam logic [CODE_W-1:0] CODE_ONE    = {{(CODE_W-1){1'b0}}, 1'b1};

    logic [2:0]        state_q,   state_d;
    logic [IDX_W-1:0]  idx_q,     idx_d;
    logic [CODE_W-1:0] lambda_q,  lambda_d;
    logic              e_q,       e_d;
    logic              busy_q,    busy_d;
    logic              done_q,    done_d;
    logic              locked_q,  locked_d;
    logic              sat_q,     sat_d;
    logic [CNT_W-1:0]  meas_q,    meas_d;
    logic              prev_q,    prev_d;
    logic [CNT_W-1:0]  cnt_q,     cnt_d;
    logic [TMR_W-1:0]  tmr_q,     tmr_d;
    logic              dir_vld_q, dir_vld_d;
    logic              dir_up_q,  dir_up_d;

    logic              dco_rise;
    logic [CNT_W:0]    cnt_ext;
    logic [CNT_W:0]    tgt_ext;
    logic [CNT_W:0]    tol_ext;
    logic              need_up;
    logic              need_down;

    // Rising edge of the synchronised DCO and the widened tolerance compare.
    always_comb begin
        dco_rise  = dco_sync & ~prev_q;
        cnt_ext   = {1'b0, cnt_q};
        tgt_ext   = {1'b0, target_cnt};
        tol_ext   = {1'b0, tol};
        // count < target - tol is rewritten as count + tol < target so that
        // nothing can underflow when tol exceeds target.
        need_up   = (cnt_ext + tol_ext) < tgt_ext;
        need_down = cnt_ext > (tgt_ext + tol_ext);
    end

    // Next-state logic for the calibration sequencer and all registered outputs.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        e_d       = e_q;
        locked_d  = locked_q;
        sat_d     = sat_q;
        meas_d    = meas_q;
        prev_d    = dco_sync;
        cnt_d     = cnt_q;
        tmr_d     = tmr_q;
        dir_vld_d = dir_vld_q;
        dir_up_d  = dir_up_q;

        case (state_q)
            S_IDLE: begin
                if (abort) begin
                    e_d = 1'b0;
                end else if (start) begin
                    state_d   = S_SETTLE;
                    idx_d     = {IDX_W{1'b0}};
                    e_d       = 1'b1;
                    locked_d  = 1'b0;
                    sat_d     = 1'b0;
                    dir_vld_d = 1'b0;
                    dir_up_d  = 1'b0;
                    tmr_d     = {TMR_W{1'b0}};
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SETTLE: begin
                if (tmr_q == SETTLE_LAST) begin
                    state_d = S_MEAS;
                    tmr_d   = {TMR_W{1'b0}};
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            S_MEAS: begin
                if (dco_rise && (cnt_q != CNT_MAX)) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    cnt_d = cnt_q;
                end
                if (tmr_q == WIN_LAST) begin
                    state_d = S_CMP;
                    tmr_d   = {TMR_W{1'b0}};
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            S_CMP: begin
                meas_d = cnt_q;
                if (need_up) begin
                    if (idx_q == IDX_LAST) begin
                        sat_d   = 1'b1;
                        state_d = S_DONE;
                    end else if (dir_vld_q && !dir_up_q) begin
                        // Direction reversed: the target lies between two codes.
                        state_d = S_DONE;
                    end else begin
                        idx_d     = idx_q + IDX_W'(1);
                        dir_vld_d = 1'b1;
                        dir_up_d  = 1'b1;
                        tmr_d     = {TMR_W{1'b0}};
                        state_d   = S_SETTLE;
                    end
                end else if (need_down) begin
                    if (idx_q == {IDX_W{1'b0}}) begin
                        sat_d   = 1'b1;
                        state_d = S_DONE;
                    end else if (dir_vld_q && dir_up_q) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d     = idx_q - IDX_W'(1);
                        dir_vld_d = 1'b1;
                        dir_up_d  = 1'b0;
                        tmr_d     = {TMR_W{1'b0}};
                        state_d   = S_SETTLE;
                    end
                end else begin
                    locked_d = 1'b1;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort from any busy state overrides whatever the sequencer decided.
        if (abort && (state_q != S_IDLE)) begin
            state_d  = S_IDLE;
            idx_d    = idx_q;
            e_d      = 1'b0;
            locked_d = 1'b0;
            sat_d    = 1'b0;
            meas_d   = meas_q;
            tmr_d    = {TMR_W{1'b0}};
        end else begin
            state_d = state_d;
        end

        lambda_d = CODE_ONE << idx_d;
        done_d   = (state_d == S_DONE);
        busy_d   = (state_d != S_IDLE);
    end

    // State and output registers; lambda resets to the index-0 code to stay one-hot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            idx_q     <= {IDX_W{1'b0}};
            lambda_q  <= CODE_ONE;
            e_q       <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            locked_q  <= 1'b0;
            sat_q     <= 1'b0;
            meas_q    <= {CNT_W{1'b0}};
            prev_q    <= 1'b0;
            cnt_q     <= {CNT_W{1'b0}};
            tmr_q     <= {TMR_W{1'b0}};
            dir_vld_q <= 1'b0;
            dir_up_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            lambda_q  <= lambda_d;
            e_q       <= e_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            locked_q  <= locked_d;
            sat_q     <= sat_d;
            meas_q    <= meas_d;
            prev_q    <= prev_d;
            cnt_q     <= cnt_d;
            tmr_q     <= tmr_d;
            dir_vld_q <= dir_vld_d;
            dir_up_q  <= dir_up_d;
        end
    end

    assign lambda   = lambda_q;
    assign e        = e_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign locked   = locked_q;
    assign sat      = sat_q;
    assign meas_cnt = meas_q;

endmodule

// File: tb/tb_dco_freq_cal.sv
// Testbench for dco_freq_cal: table of directed calibrations, randomized
// calibrations checked against an arithmetic reference model, plus abort
// and reset corner sequences. The DCO is modelled with period 2*(10-idx).
module tb_dco_freq_cal;

    localparam int CODE_W = 10;
    localparam int CNT_W  = 8;
    localparam int WIN    = 64;
    localparam int SET    = 4;
    localparam int STEP   = WIN + SET + 1;
    localparam int HMAX   = 65536;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              abort;
    logic [CNT_W-1:0]  target_cnt;
    logic [CNT_W-1:0]  tol;
    logic              dco_sync = 1'b0;
    logic [CODE_W-1:0] lambda;
    logic              e;
    logic              busy;
    logic              done;
    logic              locked;
    logic              sat;
    logic [CNT_W-1:0]  meas_cnt;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ph = 0;
    int onehot_bad = 0;
    int done_seen = 0;
    int drv_id;
    int drv_p;
    bit hist [0:HMAX-1];
    bit [CODE_W-1:0] lam_hist [0:HMAX-1];

    dco_freq_cal #(.CODE_W(CODE_W), .CNT_W(CNT_W), .WIN_CYC(WIN), .SETTLE_CYC(SET)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .target_cnt(target_cnt), .tol(tol), .dco_sync(dco_sync),
        .lambda(lambda), .e(e), .busy(busy), .done(done),
        .locked(locked), .sat(sat), .meas_cnt(meas_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // DCO model and history recorder: next dco_sync value for the coming posedge.
    always @(negedge clk) begin
        drv_id = 0;
        for (int i = 0; i < CODE_W; i++) if (lambda[i] === 1'b1) drv_id = i;
        drv_p = 2 * (10 - drv_id);
        dco_sync <= ((ph % drv_p) < (drv_p / 2));
        if (cyc + 1 < HMAX) hist[cyc + 1] <= ((ph % drv_p) < (drv_p / 2));
        if (cyc < HMAX) lam_hist[cyc] <= lambda;
        ph <= ph + 1;
        if ($countones(lambda) != 1) onehot_bad <= onehot_bad + 1;
        if (done === 1'b1) done_seen <= done_seen + 1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: walk the windows using the recorded DCO waveform and the search rules.
    task automatic ref_model(input int c0, input int tgt, input int tl,
                             output int cmp_cyc, output int r_idx, output int r_lock,
                             output int r_sat, output int r_meas, output int lam_bad);
        int idx, dir, k, ws, cnt, want;
        bit fin;
        idx = 0; dir = 0; k = 0; fin = 1'b0;
        r_lock = 0; r_sat = 0; r_meas = 0; lam_bad = 0; cmp_cyc = c0;
        while (!fin && k < 2 * CODE_W) begin
            ws = c0 + SET + 1 + STEP * k;
            if (lam_hist[ws] != (10'd1 << idx)) lam_bad++;
            cnt = 0;
            for (int q = ws; q < ws + WIN; q++)
                if (hist[q] && !hist[q - 1] && cnt < 255) cnt++;
            cmp_cyc = c0 + STEP * (k + 1);
            r_meas = cnt;
            if (cnt + tl < tgt) want = 1;
            else if (cnt > tgt + tl) want = -1;
            else want = 0;
            if (want == 0) begin
                r_lock = 1; fin = 1'b1;
            end else if (idx + want < 0 || idx + want > CODE_W - 1) begin
                r_sat = 1; fin = 1'b1;
            end else if (dir == -want) begin
                fin = 1'b1;
            end else begin
                idx = idx + want; dir = want; k++;
            end
        end
        r_idx = idx;
    endtask

    task automatic run_check(input int tgt, input int tl, output int o_idx, output int o_lock,
                             output int o_sat, output int o_meas, output int o_win);
        int c0, dc, n_cmp, lam_bad;
        @(negedge clk);
        target_cnt = CNT_W'(tgt); tol = CNT_W'(tl); start = 1'b1; c0 = cyc + 1;
        @(negedge clk);
        start = 1'b0;
        dc = -1;
        for (int n = 0; n < 1000; n++) begin
            if (done === 1'b1) begin dc = cyc; break; end
            @(negedge clk);
        end
        o_idx = -1; o_lock = -1; o_sat = -1; o_meas = -1; o_win = -1;
        if (dc < 0) begin
            chk("done_timeout", 64'd0, 64'd1);
            return;
        end
        ref_model(c0, tgt, tl, n_cmp, o_idx, o_lock, o_sat, o_meas, lam_bad);
        o_win = (n_cmp - c0) / STEP;
        chk("done_cycle", dc, n_cmp);
        chk("lambda_at_done", lambda, 64'd1 << o_idx);
        chk("locked_at_done", locked, o_lock);
        chk("sat_at_done", sat, o_sat);
        chk("meas_at_done", meas_cnt, o_meas);
        chk("e_at_done", e, 64'd1);
        chk("busy_at_done", busy, 64'd1);
        chk("lambda_per_window", lam_bad, 64'd0);
        @(negedge clk);
        chk("done_one_cycle", done, 64'd0);
        chk("busy_after_done", busy, 64'd0);
        chk("lambda_held", lambda, 64'd1 << o_idx);
        chk("e_held", e, 64'd1);
        chk("locked_held", locked, o_lock);
    endtask

    typedef struct {
        int tgt; int tl; int x_lock; int x_sat; int x_idx; int x_meas; int x_win;
    } vec_t;

    vec_t vecs [7];
    int r_idx, r_lock, r_sat, r_meas, r_win, c0, ds0;

    initial begin
        // x_meas = -1 means phase dependent, checked only by the reference model
        vecs[0] = '{8,   0,   1, 0, 6, 8,  7};
        vecs[1] = '{200, 0,   0, 1, 9, 32, 10};
        vecs[2] = '{1,   0,   0, 1, 0, -1, 1};
        vecs[3] = '{9,   0,   0, 0, 7, -1, 8};
        vecs[4] = '{0,   0,   0, 1, 0, -1, 1};
        vecs[5] = '{255, 0,   0, 1, 9, 32, 10};
        vecs[6] = '{5,   255, 1, 0, 0, -1, 1};

        ph = int'($urandom_range(0, 999));
        rst = 1'b1; start = 1'b0; abort = 1'b0; target_cnt = '0; tol = '0;
        repeat (3) @(negedge clk);
        chk("rst_lambda", lambda, 64'd1);
        chk("rst_e", e, 64'd0);
        chk("rst_busy", busy, 64'd0);
        chk("rst_done", done, 64'd0);
        chk("rst_locked", locked, 64'd0);
        chk("rst_sat", sat, 64'd0);
        chk("rst_meas", meas_cnt, 64'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Directed table
        for (int v = 0; v < 7; v++) begin
            run_check(vecs[v].tgt, vecs[v].tl, r_idx, r_lock, r_sat, r_meas, r_win);
            chk("tbl_idx", r_idx, vecs[v].x_idx);
            chk("tbl_locked", r_lock, vecs[v].x_lock);
            chk("tbl_sat", r_sat, vecs[v].x_sat);
            chk("tbl_windows", r_win, vecs[v].x_win);
            if (vecs[v].x_meas >= 0) chk("tbl_meas", r_meas, vecs[v].x_meas);
            if (v == 3) chk("tbl_meas_idx7", (r_meas == 10 || r_meas == 11), 64'd1);
        end

        // Randomized targets and DCO phase
        for (int r = 0; r < 8; r++) begin
            ph = int'($urandom_range(0, 999));
            run_check(int'($urandom_range(0, 40)), int'($urandom_range(0, 3)),
                      r_idx, r_lock, r_sat, r_meas, r_win);
        end

        // Abort in the third measurement window
        ds0 = done_seen;
        @(negedge clk);
        target_cnt = 8'd8; tol = 8'd0; start = 1'b1; c0 = cyc + 1;
        @(negedge clk);
        start = 1'b0;
        while (cyc < c0 + 2 * STEP + SET + 10) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", busy, 64'd0);
        chk("abort_e", e, 64'd0);
        chk("abort_done", done, 64'd0);
        chk("abort_lambda", lambda, 64'd4);
        chk("abort_locked", locked, 64'd0);
        chk("abort_sat", sat, 64'd0);
        repeat (5) @(negedge clk);
        chk("abort_idle", busy, 64'd0);
        chk("abort_no_done", done_seen, ds0);
        run_check(8, 0, r_idx, r_lock, r_sat, r_meas, r_win);
        chk("rerun_locked", r_lock, 64'd1);
        chk("rerun_idx", r_idx, 64'd6);

        // Reset mid-SETTLE, then start and abort together
        @(negedge clk);
        target_cnt = 8'd8; start = 1'b1; c0 = cyc + 1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("pre_rst_busy", busy, 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_lambda", lambda, 64'd1);
        chk("mid_rst_e", e, 64'd0);
        chk("mid_rst_busy", busy, 64'd0);
        chk("mid_rst_done", done, 64'd0);
        chk("mid_rst_locked", locked, 64'd0);
        chk("mid_rst_meas", meas_cnt, 64'd0);
        @(negedge clk);
        rst = 1'b0; start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk("start_abort_busy", busy, 64'd0);
        chk("start_abort_e", e, 64'd0);
        repeat (4) @(negedge clk);
        chk("start_abort_idle", busy, 64'd0);
        chk("start_abort_lambda", lambda, 64'd1);

        chk("lambda_onehot", onehot_bad, 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
